// File: rtl/pc_sequencer.sv
// Program parcel sequencer: tracks P, requests 16-parcel buffer line fills, handles branches/return jumps.
// Optional macro PC_BRANCH_CNT_EN adds a saturating taken-branch counter output o_branch_cnt.
module pc_sequencer #(
  parameter logic [23:0] RESET_P = 24'o0
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_take_branch,
  input  logic        i_rtn_jump,
  input  logic [23:0] i_nxt_p,
  input  logic        i_issue,
  input  logic        i_two_parcel,
  input  logic        i_fetch_ack,
  output logic [23:0] o_p,
  output logic        o_fetch_req,
  output logic [23:0] o_fetch_addr,
  output logic        o_flush,
  output logic        o_stall,
  output logic        o_b00_we,
  output logic [23:0] o_b00_data
`ifdef PC_BRANCH_CNT_EN
  ,
  output logic [15:0] o_branch_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_e;

  state_e      state_q, state_d;
  logic [23:0] p_q, p_d;
  logic [19:0] line_q, line_d;
  logic        pend_q, pend_d;
  logic [19:0] pend_line_q, pend_line_d;
  logic        flush_q, flush_d;
  logic        b00_we_q, b00_we_d;
  logic [23:0] b00_data_q, b00_data_d;
  logic        br_acc;
  logic [23:0] p_inc;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    line_d      = line_q;
    pend_d      = pend_q;
    pend_line_d = pend_line_q;
    flush_d     = 1'b0;
    b00_we_d    = 1'b0;
    b00_data_d  = b00_data_q;
    br_acc      = i_take_branch && (state_q != IDLE);
    p_inc       = p_q + (i_two_parcel ? 24'd2 : 24'd1);

    // A branch redirects P immediately in both FETCH and RUN; only the fetch side differs.
    if (br_acc) begin
      p_d     = i_nxt_p;
      flush_d = 1'b1;
      if (i_rtn_jump) begin
        b00_we_d   = 1'b1;
        b00_data_d = p_q + 24'd2;
      end
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        line_d  = p_q[23:4];
      end
      FETCH: begin
        if (i_fetch_ack) begin
          pend_d = 1'b0;
          if (i_take_branch)  line_d  = i_nxt_p[23:4];
          else if (pend_q)    line_d  = pend_line_q;
          else                state_d = RUN;
        end else if (i_take_branch) begin
          // Outstanding request must hold; remember where to go once it is acked.
          pend_d      = 1'b1;
          pend_line_d = i_nxt_p[23:4];
        end
      end
      RUN: begin
        if (i_take_branch) begin
          state_d = FETCH;
          line_d  = i_nxt_p[23:4];
        end else if (i_issue) begin
          p_d = p_inc;
          if (p_inc[23:4] != p_q[23:4]) begin
            state_d = FETCH;
            line_d  = p_inc[23:4];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      p_q         <= RESET_P;
      line_q      <= RESET_P[23:4];
      pend_q      <= 1'b0;
      pend_line_q <= '0;
      flush_q     <= 1'b0;
      b00_we_q    <= 1'b0;
      b00_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      line_q      <= line_d;
      pend_q      <= pend_d;
      pend_line_q <= pend_line_d;
      flush_q     <= flush_d;
      b00_we_q    <= b00_we_d;
      b00_data_q  <= b00_data_d;
    end
  end

  assign o_p          = p_q;
  assign o_fetch_req  = (state_q == FETCH);
  assign o_fetch_addr = {line_q, 4'b0000};
  assign o_flush      = flush_q;
  assign o_stall      = (state_q != RUN);
  assign o_b00_we     = b00_we_q;
  assign o_b00_data   = b00_data_q;

`ifdef PC_BRANCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (br_acc && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_branch_cnt = cnt_q;
`endif

endmodule
